// File: rtl/round_robin_arbitor.sv
// Round-robin arbiter with lock-until-release grants and registered one-hot/index outputs.
// Optional consecutive-grant limit is enabled by defining ROUND_ROBIN_ARBITOR_HOLD_LIMIT_EN.
//
// Handshake: a channel requests by raising i_request[n]; once granted it keeps the grant for
// as long as i_request[n] stays high, and releases it by sampling low at a rising clock edge.
module round_robin_arbitor #(
    parameter int WIDTH       = 4,
    parameter int INDEX_WIDTH = 2,
    parameter int HOLD_LIMIT  = 16
) (
    input  logic                   clk,
    input  logic                   rst_x,
    input  logic [WIDTH-1:0]       i_request,
    output logic [WIDTH-1:0]       o_grant,
    output logic [INDEX_WIDTH-1:0] o_index,
    output logic                   o_busy,
    output logic                   o_dbg_state
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Wide enough to hold r_last + 1 + offset (at most 2*WIDTH-1) before the wrap.
    localparam int               SUM_W   = INDEX_WIDTH + 2;
    localparam logic [SUM_W-1:0] W_WIDTH = SUM_W'(WIDTH);

    if (WIDTH < 2) begin : g_bad_width
        $error("round_robin_arbitor: WIDTH must be at least 2");
    end
    if ((1 << INDEX_WIDTH) < WIDTH) begin : g_bad_index_width
        $error("round_robin_arbitor: INDEX_WIDTH too small for WIDTH");
    end
    if (HOLD_LIMIT < 1) begin : g_bad_hold_limit
        $error("round_robin_arbitor: HOLD_LIMIT must be at least 1");
    end

    state_t                 r_state;
    logic [INDEX_WIDTH-1:0] r_last;

    logic [2*WIDTH-1:0]     w_dbl;
    logic [WIDTH-1:0]       w_rot;
    logic [SUM_W-1:0]       w_start;
    logic [SUM_W-1:0]       w_off;
    logic [SUM_W-1:0]       w_sum;
    logic                   w_found;
    logic [INDEX_WIDTH-1:0] w_win;
    logic                   w_hold;
    logic                   w_limit;

    // Rotate the request vector so bit 0 is the channel just after r_last, then take the
    // lowest set bit; r_last itself lands on the top bit and is therefore searched last.
    always_comb begin
        w_dbl   = {i_request, i_request};
        w_start = SUM_W'(r_last) + SUM_W'(1);
        w_rot   = WIDTH'(w_dbl >> w_start);
        w_found = |w_rot;
        w_off   = '0;
        for (int k = WIDTH - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = SUM_W'(k);
            end
        end
        w_sum = w_start + w_off;
        w_win = (w_sum >= W_WIDTH) ? INDEX_WIDTH'(w_sum - W_WIDTH) : INDEX_WIDTH'(w_sum);
    end

    assign w_hold      = |(o_grant & i_request);
    assign o_dbg_state = r_state;

`ifdef ROUND_ROBIN_ARBITOR_HOLD_LIMIT_EN
    localparam int CNT_W = $clog2(HOLD_LIMIT + 1);

    logic [CNT_W-1:0] r_hold_cnt;

    assign w_limit = (r_hold_cnt >= CNT_W'(HOLD_LIMIT));
`else
    assign w_limit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            r_state    <= ST_IDLE;
            r_last     <= INDEX_WIDTH'(WIDTH - 1);
            o_grant    <= '0;
            o_index    <= '0;
            o_busy     <= 1'b0;
`ifdef ROUND_ROBIN_ARBITOR_HOLD_LIMIT_EN
            r_hold_cnt <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_state    <= ST_GRANT;
                        r_last     <= w_win;
                        o_grant    <= WIDTH'(1) << w_win;
                        o_index    <= w_win;
                        o_busy     <= 1'b1;
`ifdef ROUND_ROBIN_ARBITOR_HOLD_LIMIT_EN
                        r_hold_cnt <= CNT_W'(1);
`endif
                    end
                end
                ST_GRANT: begin
                    if (w_hold && !w_limit) begin
`ifdef ROUND_ROBIN_ARBITOR_HOLD_LIMIT_EN
                        r_hold_cnt <= r_hold_cnt + CNT_W'(1);
`endif
                    end else if (w_found) begin
                        // Released (or limit hit): hand over without an idle cycle.
                        r_last     <= w_win;
                        o_grant    <= WIDTH'(1) << w_win;
                        o_index    <= w_win;
                        o_busy     <= 1'b1;
`ifdef ROUND_ROBIN_ARBITOR_HOLD_LIMIT_EN
                        r_hold_cnt <= CNT_W'(1);
`endif
                    end else begin
                        // r_last keeps the released channel so the next search starts after it.
                        r_state    <= ST_IDLE;
                        o_grant    <= '0;
                        o_index    <= '0;
                        o_busy     <= 1'b0;
`ifdef ROUND_ROBIN_ARBITOR_HOLD_LIMIT_EN
                        r_hold_cnt <= '0;
`endif
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
